// File: rtl/mips_mem_if.sv
// Bus bundle between the MIPS core/boot loader and the unified word memory.
interface mips_mem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    // boot-loader write port
    logic              load_wen;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_rdy;
    // instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              busy;

    modport slave (
        input  load_wen, load_addr, load_data,
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        output load_rdy, if_rdata, if_ack, d_rdata, d_ack, busy
    );

    modport master (
        output load_wen, load_addr, load_data,
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        input  load_rdy, if_rdata, if_ack, d_rdata, d_ack, busy
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port word memory shared by MIPS ifetch/data ports plus a boot-loader write port.
// Define MEM_RR_ARB_EN for round-robin arbitration of simultaneous requests.
module mips_mem_arbiter #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          reset,
    mips_mem_if.slave     bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic [CNT_W-1:0] WS_C = CNT_W'(WAIT_STATES);

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              port_q,     port_d;
    logic              we_q,       we_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              if_ack_q,   if_ack_d;
    logic              d_ack_q,    d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              busy_q,     busy_d;
    logic              load_rdy_q, load_rdy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              grant_c;
    logic              grant_port_c;
    logic [IDX_W-1:0]  load_idx_c;
    logic [IDX_W-1:0]  if_idx_c;
    logic [IDX_W-1:0]  d_idx_c;
    logic              op_c;
    logic              op_port_c;
    logic              op_we_c;
    logic [IDX_W-1:0]  op_idx_c;
    logic [DATA_W-1:0] op_wdata_c;
    logic              mem_we_c;
    logic [IDX_W-1:0]  mem_widx_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Word index: byte-offset bits dropped, upper bits ignored so addresses wrap.
    assign load_idx_c = bus.load_addr[IDX_W+1:2];
    assign if_idx_c   = bus.if_addr[IDX_W+1:2];
    assign d_idx_c    = bus.d_addr[IDX_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.load_addr[ADDR_W-1:IDX_W+2], bus.load_addr[1:0],
                                bus.if_addr[ADDR_W-1:IDX_W+2],   bus.if_addr[1:0],
                                bus.d_addr[ADDR_W-1:IDX_W+2],    bus.d_addr[1:0]};

    // A loader write in IDLE pre-empts any CPU grant on that edge.
    assign grant_c = (state_q == S_IDLE) && !bus.load_wen && (bus.d_req || bus.if_req);

`ifdef MEM_RR_ARB_EN
    logic rr_q, rr_d;  // port granted most recently

    always_comb begin
        grant_port_c = PORT_IF;
        rr_d         = rr_q;
        if (bus.d_req && bus.if_req) begin
            grant_port_c = (rr_q == PORT_IF) ? PORT_D : PORT_IF;
        end else if (bus.d_req) begin
            grant_port_c = PORT_D;
        end
        if (grant_c) begin
            rr_d = grant_port_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= PORT_IF;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign grant_port_c = bus.d_req ? PORT_D : PORT_IF;
`endif

    // Next-state, latched access and the memory operation performed on entering DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        op_c       = 1'b0;
        op_port_c  = port_q;
        op_we_c    = we_q;
        op_idx_c   = idx_q;
        op_wdata_c = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    port_d  = grant_port_c;
                    we_d    = (grant_port_c == PORT_D) && bus.d_we;
                    idx_d   = (grant_port_c == PORT_D) ? d_idx_c : if_idx_c;
                    wdata_d = bus.d_wdata;
                    cnt_d   = WS_C;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_DONE;
                        op_c       = 1'b1;
                        op_port_c  = port_d;
                        op_we_c    = we_d;
                        op_idx_c   = idx_d;
                        op_wdata_c = wdata_d;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    op_c    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_we_c    = 1'b0;
        mem_widx_c  = load_idx_c;
        mem_wdata_c = bus.load_data;
        if ((state_q == S_IDLE) && bus.load_wen) begin
            mem_we_c = 1'b1;
        end else if (op_c && op_we_c) begin
            mem_we_c    = 1'b1;
            mem_widx_c  = op_idx_c;
            mem_wdata_c = op_wdata_c;
        end

        if (op_c && !op_we_c) begin
            if (op_port_c == PORT_D) begin
                d_rdata_d = mem_q[op_idx_c];
            end else begin
                if_rdata_d = mem_q[op_idx_c];
            end
        end

        if_ack_d   = (state_d == S_DONE) && (port_d == PORT_IF);
        d_ack_d    = (state_d == S_DONE) && (port_d == PORT_D);
        busy_d     = (state_d != S_IDLE);
        load_rdy_d = (state_d == S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            port_q     <= PORT_IF;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
            load_rdy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
            load_rdy_q <= load_rdy_d;
        end
    end

    // Storage is not cleared by reset, and a reset edge suppresses any write.
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            mem_q[mem_widx_c] <= mem_wdata_c;
        end
    end

    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = busy_q;
    assign bus.load_rdy = load_rdy_q;

endmodule
